// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the 16-bit CPU front end.
//   Contents:
//     - datapath width, register count and register address width
//     - opcode and instruction-type constants
//     - instruction field bit positions
//     - decoded_t: per-instruction operand addresses and immediate
//     - decode():          instruction low bits -> decoded_t
//     - select_operand():  forward / write-through / register-file priority mux
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int REG_AW = 3;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [REG_AW-1:0] reg_addr_t;

    // Opcodes
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_ADDI = 4'b1001;

    // Instruction type bit values
    localparam logic TYPE_R = 1'b0;
    localparam logic TYPE_I = 1'b1;

    // Instruction field positions
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int TYPE_BIT = 11;
    localparam int RD_MSB   = 10;
    localparam int RD_LSB   = 8;
    localparam int RS_MSB   = 7;
    localparam int RS_LSB   = 5;
    localparam int RM_MSB   = 4;
    localparam int RM_LSB   = 2;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    // Operand addresses and immediate of one instruction. The opcode is not
    // part of this record because the stage passes the whole instruction
    // word downstream untouched.
    typedef struct packed {
        reg_addr_t rd;
        reg_addr_t rs;
        reg_addr_t rm;
        word_t     n;
    } decoded_t;

    // Decode the operand-bearing low bits (type bit and below).
    function automatic decoded_t decode(input logic [TYPE_BIT:0] f);
        decoded_t d;
        d.rd = f[RD_MSB:RD_LSB];
        if (f[TYPE_BIT] == TYPE_I) begin
            // I-type: the destination doubles as the source; Rm reads r0.
            d.rs = f[RD_MSB:RD_LSB];
            d.rm = '0;
            d.n  = {{(DATA_W-(IMM_MSB-IMM_LSB+1)){1'b0}}, f[IMM_MSB:IMM_LSB]};
        end else begin
            d.rs = f[RS_MSB:RS_LSB];
            d.rm = f[RM_MSB:RM_LSB];
            d.n  = '0;
        end
        return d;
    endfunction

    // Operand source priority: ALU forward, then writeback write-through,
    // then the stored register value.
    function automatic word_t select_operand(
        input reg_addr_t field,
        input word_t     rf_val,
        input logic      fwd_en,
        input reg_addr_t fwd_addr,
        input word_t     fwd_data,
        input logic      wb_en,
        input reg_addr_t wb_addr,
        input word_t     wb_data
    );
        if (fwd_en && (fwd_addr == field))
            return fwd_data;
        else if (wb_en && (wb_addr == field))
            return wb_data;
        else
            return rf_val;
    endfunction

endpackage : cpu_pkg

// File: rtl/regfile_8x16.sv
// ---------------------------------------------------------------------------
// regfile_8x16
//   8 x 16-bit architectural register file. One synchronous write port,
//   three combinational read ports, asynchronous active-high clear.
//   No bypassing here: a read in the same cycle as a write to the same
//   address returns the old value; the caller adds any bypass it needs.
//   Ports:
//     clk, reset        clock, async active-high reset
//     we, waddr, wdata  write port (applied on the rising edge)
//     raddr0..2         read addresses
//     rdata0..2         read data (combinational)
// ---------------------------------------------------------------------------
module regfile_8x16
    import cpu_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      we,
    input  reg_addr_t waddr,
    input  word_t     wdata,
    input  reg_addr_t raddr0,
    input  reg_addr_t raddr1,
    input  reg_addr_t raddr2,
    output word_t     rdata0,
    output word_t     rdata1,
    output word_t     rdata2
);

    word_t regs [NREGS];

    // NOTE: the array is built from flops, so clearing it on reset is legal;
    // an array mapped onto a RAM macro could not be reset like this.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata0 = regs[raddr0];
    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule : regfile_8x16

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//   Decode / operand-fetch stage in front of the ALU. Owns the register
//   file, decodes the instruction, reads Rd/Rs/Rm with ALU forwarding and
//   writeback write-through, builds the immediate, and presents a
//   registered valid/ready bundle.
//   Ports:
//     clk, reset                      clock, async active-high reset
//     in_valid, in_ready, in_instr    upstream handshake and instruction
//     wb_en, wb_addr, wb_data         register writeback
//     fwd_en, fwd_addr, fwd_data      ALU result forwarding
//     out_valid, out_ready            downstream handshake
//     instruction, rddata, rsdata,
//     rmdata, N                       registered output bundle
// ---------------------------------------------------------------------------
module operand_fetch
    import cpu_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      in_valid,
    output logic      in_ready,
    input  word_t     in_instr,
    input  logic      wb_en,
    input  reg_addr_t wb_addr,
    input  word_t     wb_data,
    input  logic      fwd_en,
    input  reg_addr_t fwd_addr,
    input  word_t     fwd_data,
    output logic      out_valid,
    input  logic      out_ready,
    output word_t     instruction,
    output word_t     rddata,
    output word_t     rsdata,
    output word_t     rmdata,
    output word_t     N
);

    logic  valid_q;
    word_t instr_q;
    word_t rd_q;
    word_t rs_q;
    word_t rm_q;
    word_t n_q;

    logic  accept;
    logic  stall;

    logic [TYPE_BIT:0] src_fields;
    decoded_t          dec;

    word_t rf_rd;
    word_t rf_rs;
    word_t rf_rm;
    word_t op_rd;
    word_t op_rs;
    word_t op_rm;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign stall    = valid_q && !out_ready;

    // Operands are read for the incoming instruction on accept, otherwise
    // for the held one so a stalled bundle keeps seeing fresh register
    // values until it drains.
    assign src_fields = accept ? in_instr[TYPE_BIT:0] : instr_q[TYPE_BIT:0];
    assign dec        = decode(src_fields);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    regfile_8x16 u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr0 (dec.rd),
        .raddr1 (dec.rs),
        .raddr2 (dec.rm),
        .rdata0 (rf_rd),
        .rdata1 (rf_rs),
        .rdata2 (rf_rm)
    );

    // Forward beats write-through for the operand; the array itself still
    // takes wb_data when both target the same register.
    assign op_rd = select_operand(dec.rd, rf_rd, fwd_en, fwd_addr, fwd_data,
                                  wb_en, wb_addr, wb_data);
    assign op_rs = select_operand(dec.rs, rf_rs, fwd_en, fwd_addr, fwd_data,
                                  wb_en, wb_addr, wb_data);
    assign op_rm = select_operand(dec.rm, rf_rm, fwd_en, fwd_addr, fwd_data,
                                  wb_en, wb_addr, wb_data);

    // ------------------------------------------------------------------
    // Output bundle
    // ------------------------------------------------------------------
    // NOTE: every register here uses non-blocking assignment so all flops
    // sample the pre-edge values and simulation matches the hardware.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            rm_q    <= '0;
            n_q     <= '0;
        end else if (accept) begin
            // Covers both an empty stage and a simultaneous drain+refill.
            valid_q <= 1'b1;
            instr_q <= in_instr;
            rd_q    <= op_rd;
            rs_q    <= op_rs;
            rm_q    <= op_rm;
            n_q     <= dec.n;
        end else if (stall) begin
            // Instruction and immediate hold; operands are refreshed.
            rd_q    <= op_rd;
            rs_q    <= op_rs;
            rm_q    <= op_rm;
        end else if (valid_q) begin
            // Drained with nothing new: data holds its last value.
            valid_q <= 1'b0;
        end
    end

    assign out_valid   = valid_q;
    assign instruction = instr_q;
    assign rddata      = rd_q;
    assign rsdata      = rs_q;
    assign rmdata      = rm_q;
    assign N           = n_q;

endmodule : operand_fetch

// File: tb/tb_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch
//   Self-checking bench for operand_fetch: directed sequences, a vector
//   table and randomized traffic against a behavioural model.
// ---------------------------------------------------------------------------
module tb_operand_fetch;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        fwd_en;
    logic [2:0]  fwd_addr;
    logic [15:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] instruction;
    logic [15:0] rddata;
    logic [15:0] rsdata;
    logic [15:0] rmdata;
    logic [15:0] n_out;

    operand_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .fwd_en      (fwd_en),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instruction (instruction),
        .rddata      (rddata),
        .rsdata      (rsdata),
        .rmdata      (rmdata),
        .N           (n_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [15:0] m_regs [0:7];
    logic        m_valid;
    logic [15:0] m_instr, m_rd, m_rs, m_rm, m_n;

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_valid = 1'b0;
        m_instr = 16'h0000;
        m_rd    = 16'h0000;
        m_rs    = 16'h0000;
        m_rm    = 16'h0000;
        m_n     = 16'h0000;
    endtask

    // Value an operand read of register a sees this cycle.
    function automatic logic [15:0] m_read(input int a);
        if (fwd_en && int'(fwd_addr) == a) return fwd_data;
        if (wb_en && int'(wb_addr) == a)   return wb_data;
        return m_regs[a];
    endfunction

    task automatic m_load_operands(input logic [15:0] ins);
        int rd_a, rs_a, rm_a;
        rd_a = (int'(ins) >> 8) & 7;
        if (((int'(ins) >> 11) & 1) == 1) begin
            rs_a = rd_a;
            rm_a = 0;
        end else begin
            rs_a = (int'(ins) >> 5) & 7;
            rm_a = (int'(ins) >> 2) & 7;
        end
        m_rd = m_read(rd_a);
        m_rs = m_read(rs_a);
        m_rm = m_read(rm_a);
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step();
        logic ready;
        ready = !m_valid || out_ready;
        if (in_valid && ready) begin
            m_instr = in_instr;
            m_n     = in_instr[11] ? (in_instr & 16'h00FF) : 16'h0000;
            m_load_operands(in_instr);
            m_valid = 1'b1;
        end else if (m_valid && !out_ready) begin
            m_load_operands(m_instr);
        end else if (m_valid) begin
            m_valid = 1'b0;
        end
        if (wb_en) m_regs[wb_addr] = wb_data;
    endtask

    task automatic compare_model();
        check("out_valid",   {15'd0, out_valid}, {15'd0, m_valid});
        check("in_ready",    {15'd0, in_ready},  {15'd0, (!m_valid || out_ready)});
        check("instruction", instruction, m_instr);
        check("rddata",      rddata, m_rd);
        check("rsdata",      rsdata, m_rs);
        check("rmdata",      rmdata, m_rm);
        check("N",           n_out, m_n);
    endtask

    // One clock: model and DUT both step, then outputs are compared 1ns
    // after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_instr  = 16'h0000;
        wb_en     = 1'b0;
        wb_addr   = 3'd0;
        wb_data   = 16'h0000;
        fwd_en    = 1'b0;
        fwd_addr  = 3'd0;
        fwd_data  = 16'h0000;
        out_ready = 1'b1;
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [15:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        cycle();
        wb_en   = 1'b0;
    endtask

    task automatic issue(input logic [15:0] ins);
        in_valid = 1'b1;
        in_instr = ins;
        cycle();
        in_valid = 1'b0;
    endtask

    function automatic logic [15:0] mk_r(input int rd, input int rs, input int rm);
        return {OP_ADD, TYPE_R, 3'(rd), 3'(rs), 3'(rm), 2'b00};
    endfunction

    // ------------------------------------------------------------------
    // Vector table: registers preloaded with r[i] = 0x1111 * i
    // ------------------------------------------------------------------
    typedef struct {
        logic [15:0] instr;
        logic [15:0] rd;
        logic [15:0] rs;
        logic [15:0] rm;
        logic [15:0] n;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{16'h8128, 16'h1111, 16'h1111, 16'h2222, 16'h0000};
        vecs[1] = '{16'h9B7F, 16'h3333, 16'h3333, 16'h0000, 16'h007F};
        vecs[2] = '{16'h87FC, 16'h7777, 16'h7777, 16'h7777, 16'h0000};
        vecs[3] = '{16'h8A94, 16'h2222, 16'h2222, 16'h0000, 16'h0094};
        vecs[4] = '{16'h8514, 16'h5555, 16'h0000, 16'h5555, 16'h0000};
        vecs[5] = '{16'h9FFF, 16'h7777, 16'h7777, 16'h0000, 16'h00FF};
        vecs[6] = '{16'h8063, 16'h0000, 16'h3333, 16'h0000, 16'h0000};

        idle_inputs();
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset then idle
        check("reset out_valid", {15'd0, out_valid}, 16'd0);
        check("reset in_ready",  {15'd0, in_ready},  16'd1);
        check("reset instruction", instruction, 16'h0000);
        check("reset rddata", rddata, 16'h0000);
        check("reset N", n_out, 16'h0000);
        repeat (3) cycle();
        check("idle out_valid", {15'd0, out_valid}, 16'd0);

        // Writeback then R-type read
        wb_write(3'd1, 16'h0005);
        wb_write(3'd2, 16'h0003);
        issue(16'h8128);
        check("add out_valid", {15'd0, out_valid}, 16'd1);
        check("add rsdata", rsdata, 16'h0005);
        check("add rmdata", rmdata, 16'h0003);
        check("add rddata", rddata, 16'h0005);
        check("add N", n_out, 16'h0000);
        cycle();
        check("drain out_valid", {15'd0, out_valid}, 16'd0);
        check("drain holds rsdata", rsdata, 16'h0005);

        // I-type immediate; r0 nonzero so Rm = r0 is observable
        wb_write(3'd3, 16'h1234);
        wb_write(3'd0, 16'hBEEF);
        issue(16'h9B7F);
        check("addi rsdata", rsdata, 16'h1234);
        check("addi rddata", rddata, 16'h1234);
        check("addi N", n_out, 16'h007F);
        check("addi rmdata", rmdata, 16'hBEEF);
        cycle();

        // Bypass priority: forward beats write-through, array takes wb
        wb_en    = 1'b1; wb_addr  = 3'd2; wb_data  = 16'h00AA;
        fwd_en   = 1'b1; fwd_addr = 3'd2; fwd_data = 16'h00BB;
        issue(16'h8128);
        wb_en  = 1'b0;
        fwd_en = 1'b0;
        check("bypass rmdata", rmdata, 16'h00BB);
        check("bypass rsdata", rsdata, 16'h0005);
        issue(16'h8140);
        check("r2 after bypass", rsdata, 16'h00AA);
        cycle();

        // Stall refresh: capture, 3 stalled cycles, drain + accept together
        out_ready = 1'b0;
        issue(16'h8128);
        check("stall capture valid", {15'd0, out_valid}, 16'd1);
        in_valid = 1'b1;
        in_instr = 16'h9B7F;
        #1;
        check("stall in_ready 1", {15'd0, in_ready}, 16'd0);
        cycle();
        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h0FFF;
        cycle();
        wb_en = 1'b0;
        check("stall in_ready 2", {15'd0, in_ready}, 16'd0);
        cycle();
        check("stall instruction held", instruction, 16'h8128);
        check("stall rsdata refreshed", rsdata, 16'h0FFF);
        out_ready = 1'b1;
        #1;
        check("drain in_ready", {15'd0, in_ready}, 16'd1);
        cycle();
        in_valid = 1'b0;
        check("refill instruction", instruction, 16'h9B7F);
        check("refill out_valid", {15'd0, out_valid}, 16'd1);
        check("refill rsdata", rsdata, 16'h1234);
        cycle();

        // Reset mid-stall
        out_ready = 1'b0;
        issue(16'h8128);
        #2;
        reset = 1'b1;
        #1;
        check("midreset out_valid", {15'd0, out_valid}, 16'd0);
        check("midreset instruction", instruction, 16'h0000);
        check("midreset rsdata", rsdata, 16'h0000);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(mk_r(i, i, 7 - i));
            check("post-reset rddata", rddata, 16'h0000);
            check("post-reset rmdata", rmdata, 16'h0000);
        end
        cycle();

        // Vector table, issued back to back
        for (int i = 0; i < 8; i++) wb_write(3'(i), 16'(16'h1111 * i));
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            cycle();
            check("vec out_valid", {15'd0, out_valid}, 16'd1);
            check("vec instruction", instruction, vecs[i].instr);
            check("vec rddata", rddata, vecs[i].rd);
            check("vec rsdata", rsdata, vecs[i].rs);
            check("vec rmdata", rmdata, vecs[i].rm);
            check("vec N", n_out, vecs[i].n);
        end
        in_valid = 1'b0;
        cycle();

        // Randomized traffic against the model
        begin
            logic held;
            held = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                if (!held) begin
                    in_instr = 16'($urandom);
                    in_valid = ($urandom_range(3, 0) != 0);
                end
                out_ready = ($urandom_range(2, 0) != 0);
                wb_en     = 1'($urandom_range(1, 0));
                wb_addr   = 3'($urandom_range(7, 0));
                wb_data   = 16'($urandom);
                fwd_en    = 1'($urandom_range(1, 0));
                fwd_addr  = 3'($urandom_range(7, 0));
                fwd_data  = 16'($urandom);
                // An unaccepted instruction must stay stable next cycle.
                held = in_valid && m_valid && !out_ready;
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_operand_fetch
